i2c_reg_bank: RTL and testbench

Byte-addressed register bank that sits directly downstream of `i2c_slave` and consumes its byte-level handshake (`hitar`, `write_data`/`write_en`, `read_data`/`read_en`, start/restart/stop flags). It gives the slave EEPROM-style (24Cxx) semantics:

- the first byte written after address match loads an internal word pointer;
- each following written byte is stored at the pointer, then the pointer advances;
- reads stream bytes from the pointer with auto-increment.

A local host read port and a write-event strobe expose the contents to the rest of the chip.

---
 rtl/i2c_reg_pkg.sv | 21 ++
 rtl/i2c_reg_mem.sv | 52 +++++
 rtl/i2c_reg_bank.sv | 122 ++++++++++++
 tb/tb_i2c_reg_bank.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_reg_pkg.sv
// ============================================================================
// Module   : i2c_reg_pkg
// Purpose  : Shared types and defaults for the I2C EEPROM-style register bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_reg_pkg;

    localparam int         C_ADDR_W  = 8;
    localparam logic [7:0] C_RST_VAL = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ADDRESSED = 2'd1,
        ST_DATA      = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/i2c_reg_mem.sv
// ============================================================================
// Module   : i2c_reg_mem
// Purpose  : Flop array, one write port, two registered read ports (I2C, host).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_reg_mem
    import i2c_reg_pkg::*;
#(
    parameter int         ADDR_W  = C_ADDR_W,
    parameter logic [7:0] RST_VAL = C_RST_VAL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic [ADDR_W-1:0] i_raddr_a,
    output logic [7:0]        o_rdata_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [7:0]        o_rdata_b
);

    localparam int C_DEPTH = 2**ADDR_W;

    logic [7:0] r_mem [C_DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < C_DEPTH; i++) begin
                r_mem[i] <= RST_VAL;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read ports sample the pre-write array, so a new byte shows up one cycle after the write edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_rdata_a <= 8'h00;
            o_rdata_b <= 8'h00;
        end else begin
            o_rdata_a <= r_mem[i_raddr_a];
            o_rdata_b <= r_mem[i_raddr_b];
        end
    end

endmodule

`default_nettype wire

// File: rtl/i2c_reg_bank.sv
// ============================================================================
// Module   : i2c_reg_bank
// Purpose  : 24Cxx-style register bank behind i2c_slave: pointer FSM + array.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_reg_bank
    import i2c_reg_pkg::*;
#(
    parameter int         ADDR_W  = C_ADDR_W,
    parameter logic [7:0] RST_VAL = C_RST_VAL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hitar,
    input  logic              flag_start,
    input  logic              flag_restart,
    input  logic              flag_stop,
    input  logic [7:0]        write_data,
    input  logic              write_en,
    output logic [7:0]        read_data,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] host_addr,
    output logic [7:0]        host_rdata,
    output logic              reg_wr,
    output logic [ADDR_W-1:0] reg_wr_addr,
    output logic              busy
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic              w_mem_we;
    logic              r_reg_wr;
    logic [ADDR_W-1:0] r_reg_wr_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // The byte is handled under the current state first; flags then override the next state.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_mem_we    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (hitar) begin
                    w_state_nxt = ST_ADDRESSED;
                end
            end
            ST_ADDRESSED: begin
                if (write_en) begin
                    w_ptr_nxt   = ADDR_W'(write_data);
                    w_state_nxt = ST_DATA;
                end else if (read_en) begin
                    w_ptr_nxt   = r_ptr + 1'b1;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (write_en) begin
                    w_mem_we  = 1'b1;
                    w_ptr_nxt = r_ptr + 1'b1;
                end else if (read_en) begin
                    w_ptr_nxt = r_ptr + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (flag_start || flag_stop) begin
            w_state_nxt = ST_IDLE;
        end
        if (flag_restart) begin
            w_state_nxt = ST_ADDRESSED;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reg_wr      <= 1'b0;
            r_reg_wr_addr <= '0;
        end else begin
            r_reg_wr <= w_mem_we;
            if (w_mem_we) begin
                r_reg_wr_addr <= r_ptr;
            end
        end
    end

    i2c_reg_mem #(
        .ADDR_W  (ADDR_W),
        .RST_VAL (RST_VAL)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_mem_we),
        .i_waddr   (r_ptr),
        .i_wdata   (write_data),
        .i_raddr_a (r_ptr),
        .o_rdata_a (read_data),
        .i_raddr_b (host_addr),
        .o_rdata_b (host_rdata)
    );

    assign reg_wr      = r_reg_wr;
    assign reg_wr_addr = r_reg_wr_addr;
    assign busy        = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_i2c_reg_bank.sv
// ============================================================================
// Module   : tb_i2c_reg_bank
// Purpose  : Self-checking bench for i2c_reg_bank against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_reg_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hitar = 1'b0;
    logic       flag_start = 1'b0;
    logic       flag_restart = 1'b0;
    logic       flag_stop = 1'b0;
    logic [7:0] write_data = 8'h00;
    logic       write_en = 1'b0;
    logic [7:0] read_data;
    logic       read_en = 1'b0;
    logic [7:0] host_addr = 8'h00;
    logic [7:0] host_rdata;
    logic       reg_wr;
    logic [7:0] reg_wr_addr;
    logic       busy;

    int n_pass  = 0;
    int n_total = 0;

    // Transaction-level model: array contents, word pointer, expected write events.
    logic [7:0] m_mem [256];
    logic [7:0] m_ptr;
    logic [7:0] exp_wr [$];
    logic [7:0] got_wr [$];

    i2c_reg_bank dut (
        .clk          (clk),
        .rst          (rst),
        .hitar        (hitar),
        .flag_start   (flag_start),
        .flag_restart (flag_restart),
        .flag_stop    (flag_stop),
        .write_data   (write_data),
        .write_en     (write_en),
        .read_data    (read_data),
        .read_en      (read_en),
        .host_addr    (host_addr),
        .host_rdata   (host_rdata),
        .reg_wr       (reg_wr),
        .reg_wr_addr  (reg_wr_addr),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reg_wr === 1'b1) got_wr.push_back(reg_wr_addr);
    end

    function automatic void model_reset();
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        m_ptr = 8'h00;
    endfunction

    function automatic void model_write(input logic [7:0] q[$]);
        m_ptr = q[0];
        for (int i = 1; i < q.size(); i++) begin
            m_mem[m_ptr] = q[i];
            exp_wr.push_back(m_ptr);
            m_ptr = 8'((int'(m_ptr) + 1) % 256);
        end
    endfunction

    function automatic logic [7:0] model_pop();
        logic [7:0] v;
        v     = m_mem[m_ptr];
        m_ptr = 8'((int'(m_ptr) + 1) % 256);
        return v;
    endfunction

    task automatic drv_hitar();
        @(posedge clk); #1 hitar = 1'b1;
        @(posedge clk); #1 hitar = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic drv_wr(input logic [7:0] b);
        @(posedge clk); #1 write_data = b; write_en = 1'b1;
        @(posedge clk); #1 write_en = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic drv_rd(output logic [7:0] b);
        @(posedge clk); #1 b = read_data; read_en = 1'b1;
        @(posedge clk); #1 read_en = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic drv_flag(input int which);
        @(posedge clk); #1;
        case (which)
            0:       flag_start   = 1'b1;
            1:       flag_restart = 1'b1;
            default: flag_stop    = 1'b1;
        endcase
        @(posedge clk); #1 flag_start = 1'b0; flag_restart = 1'b0; flag_stop = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic drv_write_txn(input logic [7:0] q[$]);
        drv_hitar();
        foreach (q[i]) drv_wr(q[i]);
        drv_flag(2);
    endtask

    task automatic host_rd(input logic [7:0] a, output logic [7:0] d);
        @(posedge clk); #1 host_addr = a;
        @(posedge clk); #1 d = host_rdata;
    endtask

    task automatic clear_events();
        exp_wr.delete();
        got_wr.delete();
    endtask

    task automatic test_reset();
        logic [7:0] d;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        n_total++; if (read_data !== 8'h00) $display("FAIL reset_read_data got %h exp 00", read_data); else n_pass++;
        n_total++; if (host_rdata !== 8'h00) $display("FAIL reset_host_rdata got %h exp 00", host_rdata); else n_pass++;
        n_total++; if (reg_wr !== 1'b0 || reg_wr_addr !== 8'h00)
            $display("FAIL reset_reg_wr got %b/%h exp 0/00", reg_wr, reg_wr_addr); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
        host_rd(8'hA5, d);
        n_total++; if (d !== 8'h00) $display("FAIL reset_mem got %h exp 00", d); else n_pass++;
    endtask

    task automatic test_ptr_write();
        logic [7:0] d;
        clear_events();
        drv_hitar();
        n_total++; if (busy !== 1'b1) $display("FAIL busy_after_hitar got %b exp 1", busy); else n_pass++;
        drv_wr(8'h01);
        drv_wr(8'h02);
        drv_flag(2);
        model_write('{8'h01, 8'h02});
        host_rd(8'h01, d);
        n_total++; if (d !== m_mem[8'h01]) $display("FAIL ptrwr_mem01 got %h exp %h", d, m_mem[8'h01]); else n_pass++;
        n_total++; if (got_wr.size() != 1 || got_wr[0] !== 8'h01)
            $display("FAIL ptrwr_events got %0d events first %h exp 1 event 01", got_wr.size(), (got_wr.size() > 0) ? got_wr[0] : 8'hxx);
        else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL busy_after_stop got %b exp 0", busy); else n_pass++;
    endtask

    task automatic test_burst();
        logic [7:0] q[$];
        logic [7:0] d;
        bit         ok;
        clear_events();
        q = '{8'hC0, 8'hB0, 8'hA0, 8'hCC, 8'hEF, 8'hCD, 8'hB2, 8'hA0};
        drv_write_txn(q);
        model_write(q);
        for (int a = 8'hC0; a <= 8'hC6; a++) begin
            host_rd(8'(a), d);
            n_total++; if (d !== m_mem[a]) $display("FAIL burst_mem%h got %h exp %h", a[7:0], d, m_mem[a]); else n_pass++;
        end
        ok = (got_wr.size() == exp_wr.size());
        foreach (exp_wr[i]) if (ok && got_wr[i] !== exp_wr[i]) ok = 1'b0;
        n_total++; if (!ok) $display("FAIL burst_events got %0d events exp %0d", got_wr.size(), exp_wr.size()); else n_pass++;
        n_total++; if (read_data !== m_mem[m_ptr]) $display("FAIL burst_ptr read_data %h exp %h", read_data, m_mem[m_ptr]); else n_pass++;
    endtask

    task automatic test_current_read();
        logic [7:0] d;
        logic [7:0] e;
        drv_hitar();
        drv_rd(d);
        e = model_pop();
        n_total++; if (d !== e) $display("FAIL cur_read got %h exp %h", d, e); else n_pass++;
        drv_flag(2);
        n_total++; if (m_ptr !== 8'hC8 || read_data !== m_mem[m_ptr])
            $display("FAIL cur_read_ptr read_data %h exp %h", read_data, m_mem[m_ptr]); else n_pass++;
    endtask

    task automatic test_random_read();
        logic [7:0] d;
        logic [7:0] e;
        drv_hitar();
        drv_wr(8'hC2);
        model_write('{8'hC2});
        drv_flag(1);
        drv_hitar();
        for (int i = 0; i < 2; i++) begin
            drv_rd(d);
            e = model_pop();
            n_total++; if (d !== e) $display("FAIL rand_read%0d got %h exp %h", i, d, e); else n_pass++;
        end
        drv_flag(2);
        n_total++; if (read_data !== m_mem[8'hC4]) $display("FAIL rand_read_ptr read_data %h exp %h", read_data, m_mem[8'hC4]); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [7:0] d;
        clear_events();
        drv_write_txn('{8'hFF, 8'h11, 8'h22});
        model_write('{8'hFF, 8'h11, 8'h22});
        host_rd(8'hFF, d);
        n_total++; if (d !== 8'h11) $display("FAIL wrap_memFF got %h exp 11", d); else n_pass++;
        host_rd(8'h00, d);
        n_total++; if (d !== 8'h22) $display("FAIL wrap_mem00 got %h exp 22", d); else n_pass++;
        n_total++; if (got_wr.size() != 2 || got_wr[1] !== 8'h00)
            $display("FAIL wrap_events got %0d events exp 2 ending 00", got_wr.size()); else n_pass++;
        drv_hitar();
        drv_rd(d);
        drv_flag(2);
        n_total++; if (d !== model_pop()) $display("FAIL wrap_ptr01 got %h exp %h", d, m_mem[8'h01]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        clear_events();
        drv_hitar();
        drv_wr(8'h10);
        drv_wr(8'hAA);
        drv_wr(8'hBB);
        drv_wr(8'hCC);
        @(posedge clk); #3 rst = 1'b1;
        model_reset();
        #1;
        n_total++; if (busy !== 1'b0 || read_data !== 8'h00)
            $display("FAIL midrst_async busy %b read_data %h exp 0/00", busy, read_data); else n_pass++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int a = 8'h10; a <= 8'h12; a++) begin
            host_rd(8'(a), d);
            n_total++; if (d !== m_mem[a]) $display("FAIL midrst_mem%h got %h exp %h", a[7:0], d, m_mem[a]); else n_pass++;
        end
        clear_events();
        for (int i = 0; i < 3; i++) drv_wr(8'h55 + 8'(i));
        n_total++; if (got_wr.size() != 0) $display("FAIL idle_filter_events got %0d exp 0", got_wr.size()); else n_pass++;
        host_rd(8'h00, d);
        n_total++; if (d !== 8'h00) $display("FAIL idle_filter_mem00 got %h exp 00", d); else n_pass++;
        n_total++; if (busy !== 1'b0 || read_data !== m_mem[m_ptr])
            $display("FAIL idle_filter_state busy %b read_data %h exp 0/%h", busy, read_data, m_mem[m_ptr]); else n_pass++;
    endtask

    task automatic test_random_traffic();
        logic [7:0] q[$];
        logic [7:0] d;
        logic [7:0] e;
        int         kind;
        int         n;
        bit         ok;
        clear_events();
        for (int t = 0; t < 24; t++) begin
            kind = $urandom_range(0, 2);
            n    = $urandom_range(1, 4);
            if (kind == 0) begin
                q.delete();
                q.push_back(8'($urandom_range(0, 255)));
                for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
                drv_write_txn(q);
                model_write(q);
            end else begin
                drv_hitar();
                if (kind == 2) begin
                    d = 8'($urandom_range(0, 255));
                    drv_wr(d);
                    model_write('{d});
                    drv_flag(1);
                    drv_hitar();
                end
                for (int i = 0; i < n; i++) begin
                    drv_rd(d);
                    e = model_pop();
                    n_total++; if (d !== e) $display("FAIL rnd_pop t%0d i%0d got %h exp %h", t, i, d, e); else n_pass++;
                end
                drv_flag($urandom_range(0, 1) == 0 ? 2 : 0);
            end
        end
        ok = (got_wr.size() == exp_wr.size());
        foreach (exp_wr[i]) if (ok && got_wr[i] !== exp_wr[i]) ok = 1'b0;
        n_total++; if (!ok) $display("FAIL rnd_events got %0d events exp %0d", got_wr.size(), exp_wr.size()); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            e = 8'($urandom_range(0, 255));
            host_rd(e, d);
            n_total++; if (d !== m_mem[e]) $display("FAIL rnd_host %h got %h exp %h", e, d, m_mem[e]); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_ptr_write();
        test_burst();
        test_current_read();
        test_random_read();
        test_wrap();
        test_reset_mid();
        test_random_traffic();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
